// File: rtl/branch_predictor_table_if.sv
// Fetch/execute-side bundle for the branch predictor table: prediction lookup,
// resolved-branch update and statistics readout.
interface branch_predictor_table_if #(
    parameter int GHR_W = 0
);
    localparam int GW = (GHR_W > 0) ? GHR_W : 1;

    logic [31:0]   pred_pc;
    logic          pred_taken;
    logic [1:0]    pred_code;
    logic [GW-1:0] pred_ghr;

    logic          upd_valid;
    logic [31:0]   upd_pc;
    logic [GW-1:0] upd_ghr;
    logic          upd_taken;
    logic          upd_pred;

    logic          stats_clr;
    logic [31:0]   branch_cnt;
    logic [31:0]   mispred_cnt;

    modport master (
        output pred_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_pred, stats_clr,
        input  pred_taken, pred_code, pred_ghr, branch_cnt, mispred_cnt
    );

    modport slave (
        input  pred_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_pred, stats_clr,
        output pred_taken, pred_code, pred_ghr, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predictor_table.sv
// PC-indexed saturating-counter predictor (bimodal or gshare); prediction is
// combinational with zero latency, updates land on the next edge, no backpressure.
module branch_predictor_table #(
    parameter int ENTRIES  = 64,
    parameter int CNT_W    = 2,
    parameter int GHR_W    = 0,
    parameter int CNT_INIT = 1
) (
    input logic                     clk,
    input logic                     rst_n,
    branch_predictor_table_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int GW    = (GHR_W > 0) ? GHR_W : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(CNT_INIT);

    logic [CNT_W-1:0] cnt [ENTRIES];
    logic [GW-1:0]    ghr;
    logic [IDX_W-1:0] pred_hist;
    logic [IDX_W-1:0] upd_hist;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [31:0]      branch_cnt;
    logic [31:0]      mispred_cnt;
    logic             unused_bits;

    // History is zero-extended into the low index bits; bimodal uses no history.
    generate
        if (GHR_W > 0) begin : g_hist
            always_comb begin
                pred_hist           = '0;
                upd_hist            = '0;
                pred_hist[GW-1:0]   = ghr;
                upd_hist[GW-1:0]    = bus.upd_ghr;
            end
        end else begin : g_nohist
            assign pred_hist = '0;
            assign upd_hist  = '0;
        end
    endgenerate

    assign pred_idx = bus.pred_pc[IDX_W+1:2] ^ pred_hist;
    assign upd_idx  = bus.upd_pc[IDX_W+1:2] ^ upd_hist;

    assign bus.pred_taken  = cnt[pred_idx][CNT_W-1];
    assign bus.pred_code   = {bus.pred_taken, ~bus.pred_taken};
    assign bus.pred_ghr    = ghr;
    assign bus.branch_cnt  = branch_cnt;
    assign bus.mispred_cnt = mispred_cnt;

    assign unused_bits = ^{bus.pred_pc[31:IDX_W+2], bus.pred_pc[1:0],
                           bus.upd_pc[31:IDX_W+2], bus.upd_pc[1:0], bus.upd_ghr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt[i] <= CNT_RST;
            end
        end else if (bus.upd_valid) begin
            if (bus.upd_taken) begin
                if (cnt[upd_idx] != CNT_MAX) begin
                    cnt[upd_idx] <= cnt[upd_idx] + 1'b1;
                end
            end else if (cnt[upd_idx] != '0) begin
                cnt[upd_idx] <= cnt[upd_idx] - 1'b1;
            end
        end
    end

    // History shifts only at resolve time, so it never needs repair.
    generate
        if (GHR_W == 0) begin : g_no_ghr
            assign ghr = '0;
        end else if (GHR_W == 1) begin : g_ghr1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ghr <= '0;
                end else if (bus.upd_valid) begin
                    ghr <= bus.upd_taken;
                end
            end
        end else begin : g_ghrn
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ghr <= '0;
                end else if (bus.upd_valid) begin
                    ghr <= {ghr[GW-2:0], bus.upd_taken};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (bus.stats_clr) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (bus.upd_valid) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (bus.upd_taken != bus.upd_pred) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end
endmodule
